// File: rtl/spart_rx_fifo.sv
// SPART UART receiver: oversampled start/data/parity/stop framing feeding a
// first-word-fall-through FIFO, with sticky framing, parity and overrun flags.
module spart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_enable,
  input  logic                        rxd,
  input  logic                        read,
  input  logic                        err_clr,
  output logic                        rda,
  output logic [DATA_BITS-1:0]        rx_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        framing_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // True when data plus received parity bit disagree with the configured sense
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic par_bit);
    parity_bad = ((^data) ^ par_bit) != ODD_PAR;
  endfunction

  logic                 sync1_r;
  logic                 sync2_r;
  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [BW-1:0]        bit_r;
  logic [BW-1:0]        bit_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 par_bad_r;
  logic                 par_bad_s;
  logic                 push_s;
  logic                 set_fe_s;
  logic                 set_pe_s;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [NW-1:0]        count_r;
  logic [NW-1:0]        count_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 wr_s;
  logic                 ovr_s;
  logic                 rda_r;
  logic                 fe_r;
  logic                 pe_r;
  logic                 ov_r;

  // Two-flop synchronizer on the asynchronous serial line, idling high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  // Receiver state, tick counter, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_r     <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_bad_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      par_bad_r <= par_bad_s;
    end
  end

  // Frame sequencing; every sample is taken mid-bit on an rx_enable tick
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    par_bad_s = par_bad_r;
    push_s    = 1'b0;
    set_fe_s  = 1'b0;
    set_pe_s  = 1'b0;
    if (rx_enable) begin
      case (state_r)
        S_IDLE: begin
          if (!sync2_r) begin
            state_s   = S_START;
            cnt_s     = CW'(1);
            bit_s     = {BW{1'b0}};
            par_bad_s = 1'b0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_START: begin
          if (cnt_r == HALF_TICK) begin
            cnt_s   = {CW{1'b0}};
            bit_s   = {BW{1'b0}};
            state_s = sync2_r ? S_IDLE : S_DATA;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_r == LAST_TICK) begin
            cnt_s   = {CW{1'b0}};
            shift_s = {sync2_r, shift_r[DATA_BITS-1:1]};
            if (bit_r == LAST_BIT) begin
              bit_s   = {BW{1'b0}};
              state_s = HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              bit_s = bit_r + BW'(1);
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_r == LAST_TICK) begin
            cnt_s     = {CW{1'b0}};
            par_bad_s = parity_bad(shift_r, sync2_r);
            state_s   = S_STOP;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_r == LAST_TICK) begin
            cnt_s = {CW{1'b0}};
            if (sync2_r) begin
              state_s  = S_IDLE;
              push_s   = !par_bad_r;
              set_pe_s = par_bad_r;
            end else begin
              // A low stop bit flags once, then waits out the break
              state_s  = S_BREAK;
              set_fe_s = 1'b1;
              set_pe_s = par_bad_r;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        S_BREAK: begin
          if (sync2_r) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_BREAK;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    pop_s   = read && (count_r != {NW{1'b0}});
    full_s  = (count_r == FULL_CNT);
    wr_s    = push_s && (!full_s || pop_s);
    ovr_s   = push_s && full_s && !pop_s;
    count_s = count_r + NW'(wr_s) - NW'(pop_s);
  end

  // Character storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
      rda_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
      count_r  <= count_s;
      rda_r    <= (count_s != {NW{1'b0}});
    end
  end

  // Sticky error flags; a set event overrides a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_r <= 1'b0;
      pe_r <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      fe_r <= (fe_r && !err_clr) || set_fe_s;
      pe_r <= (pe_r && !err_clr) || set_pe_s;
      ov_r <= (ov_r && !err_clr) || ovr_s;
    end
  end

  assign rda         = rda_r;
  assign rx_out      = mem_r[rd_ptr_r];
  assign fifo_count  = count_r;
  assign framing_err = fe_r;
  assign parity_err  = pe_r;
  assign overrun     = ov_r;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: two instances (8N1/16x and 8E1/8x) checked every cycle
// against a tick-count frame model with queue-based FIFOs, plus directed literals.
module tb_spart_rx_fifo;

  localparam int TDIV  = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rxd_v [2];
  logic       rd_v  [2];
  logic       clr_v [2];
  logic       rda_v [2];
  logic [7:0] out_v [2];
  logic [2:0] cnt_v [2];
  logic       fe_v  [2];
  logic       pe_v  [2];
  logic       ov_v  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxd(rxd_v[0]), .read(rd_v[0]), .err_clr(clr_v[0]),
    .rda(rda_v[0]), .rx_out(out_v[0]), .fifo_count(cnt_v[0]),
    .framing_err(fe_v[0]), .parity_err(pe_v[0]), .overrun(ov_v[0]));

  spart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxd(rxd_v[1]), .read(rd_v[1]), .err_clr(clr_v[1]),
    .rda(rda_v[1]), .rx_out(out_v[1]), .fifo_count(cnt_v[1]),
    .framing_err(fe_v[1]), .parity_err(pe_v[1]), .overrun(ov_v[1]));

  function automatic int os_of(input int c);
    return (c == 0) ? 16 : 8;
  endfunction

  function automatic int pe_of(input int c);
    return (c == 0) ? 0 : 1;
  endfunction

  // ---------------- reference model ----------------
  logic       m_sy1 [2];
  logic       m_sy2 [2];
  int         m_mode[2];   // 0 idle, 1 in frame, 2 waiting out a break
  int         m_age [2];   // ticks since the start edge was seen
  logic [7:0] m_data[2];
  logic       m_par [2];
  logic       m_fe  [2];
  logic       m_pe  [2];
  logic       m_ov  [2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic int qsize(input int c);
    if (c == 0) return q0.size();
    else return q1.size();
  endfunction

  function automatic logic [7:0] qhead(input int c);
    if (c == 0) return q0[0];
    else return q1[0];
  endfunction

  function automatic logic m_stop_next(input int c);
    return (m_mode[c] == 1) && (m_age[c] + 1 == os_of(c) / 2 + (9 + pe_of(c)) * os_of(c));
  endfunction

  task automatic model_step(input int c);
    int   os, k;
    logic v, mism, push, fes, pes, pop, full;
    os = os_of(c); v = m_sy2[c];
    push = 1'b0; fes = 1'b0; pes = 1'b0;
    if (rx_enable) begin
      if (m_mode[c] == 0) begin
        if (!v) begin m_mode[c] = 1; m_age[c] = 0; end
      end else if (m_mode[c] == 2) begin
        if (v) m_mode[c] = 0;
      end else begin
        m_age[c] = m_age[c] + 1;
        if (m_age[c] == os / 2) begin
          if (v) m_mode[c] = 0;
        end else if (m_age[c] > os / 2 && (m_age[c] - os / 2) % os == 0) begin
          k = (m_age[c] - os / 2) / os;
          if (k <= 8) m_data[c][k-1] = v;
          else if (k < 9 + pe_of(c)) m_par[c] = v;
          else begin
            mism = (pe_of(c) != 0) && (((^m_data[c]) ^ m_par[c]) != 1'b0);
            m_mode[c] = v ? 0 : 2;
            fes  = !v;
            pes  = mism;
            push = v && !mism;
          end
        end
      end
    end
    full = (qsize(c) == DEPTH);
    pop  = rd_v[c] && (qsize(c) != 0);
    if (pop) begin
      if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (push && full && !pop) m_ov[c] = 1'b1;
    else if (push) begin
      if (c == 0) q0.push_back(m_data[c]); else q1.push_back(m_data[c]);
    end
    m_fe[c] = (m_fe[c] && !clr_v[c]) || fes;
    m_pe[c] = (m_pe[c] && !clr_v[c]) || pes;
    m_ov[c] = (m_ov[c] && !clr_v[c]) || (push && full && !pop);
    m_sy2[c] = m_sy1[c];
    m_sy1[c] = rxd_v[c];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_sy1[c] = 1'b1; m_sy2[c] = 1'b1; m_mode[c] = 0; m_age[c] = 0;
        m_fe[c] = 1'b0; m_pe[c] = 1'b0; m_ov[c] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int c = 0; c < 2; c++) model_step(c);
    end
  end

  task automatic cmp(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ch%0d: got=%0h expected=%0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      cmp("rda", c, 32'(rda_v[c]), 32'(qsize(c) != 0));
      cmp("fifo_count", c, 32'(cnt_v[c]), 32'(qsize(c)));
      if (qsize(c) != 0) cmp("rx_out", c, 32'(out_v[c]), 32'(qhead(c)));
      cmp("framing_err", c, 32'(fe_v[c]), 32'(m_fe[c]));
      cmp("parity_err", c, 32'(pe_v[c]), 32'(m_pe[c]));
      cmp("overrun", c, 32'(ov_v[c]), 32'(m_ov[c]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % TDIV;
      rx_enable = (tcnt == 0);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send(input int c, input logic [7:0] d, input logic par_flip,
                      input logic stop_val, input logic pop_at_push);
    int bt;
    bt = os_of(c) * TDIV;
    rxd_v[c] = 1'b0; wait_clks(bt);
    for (int i = 0; i < 8; i++) begin rxd_v[c] = d[i]; wait_clks(bt); end
    if (pe_of(c) != 0) begin rxd_v[c] = (^d) ^ par_flip; wait_clks(bt); end
    rxd_v[c] = stop_val;
    if (pop_at_push) begin
      for (int i = 0; i < bt; i++) begin
        rd_v[c] = rx_enable && m_stop_next(c);
        wait_clks(1);
      end
      rd_v[c] = 1'b0;
    end else begin
      wait_clks(bt);
    end
    wait_clks(bt / 2);
  endtask

  task automatic pop(input int c);
    rd_v[c] = 1'b1; wait_clks(1); rd_v[c] = 1'b0; wait_clks(1);
  endtask

  task automatic clear(input int c);
    clr_v[c] = 1'b1; wait_clks(1); clr_v[c] = 1'b0; wait_clks(1);
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] nb;
    for (int c = 0; c < 2; c++) begin rxd_v[c] = 1'b1; rd_v[c] = 1'b0; clr_v[c] = 1'b0; end
    rst = 1'b1;
    wait_clks(3);
    cmp("reset rda", 0, 32'(rda_v[0]), 32'd0);
    cmp("reset count", 0, 32'(cnt_v[0]), 32'd0);
    cmp("reset flags", 0, 32'({fe_v[0], pe_v[0], ov_v[0]}), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // 1: single character
    send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    cmp("t1 rda", 0, 32'(rda_v[0]), 32'd1);
    cmp("t1 rx_out", 0, 32'(out_v[0]), 32'hA5);
    cmp("t1 count", 0, 32'(cnt_v[0]), 32'd1);
    pop(0);
    cmp("t1 rda after read", 0, 32'(rda_v[0]), 32'd0);

    // 2: overflow by one
    for (int i = 1; i <= 5; i++) send(0, 8'(8'h11 * i), 1'b0, 1'b1, 1'b0);
    cmp("t2 count", 0, 32'(cnt_v[0]), 32'd4);
    cmp("t2 overrun", 0, 32'(ov_v[0]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cmp("t2 head", 0, 32'(out_v[0]), 32'(8'h11 * i));
      pop(0);
    end
    cmp("t2 rda empty", 0, 32'(rda_v[0]), 32'd0);
    pop(0);
    cmp("t2 underflow count", 0, 32'(cnt_v[0]), 32'd0);
    clear(0);
    cmp("t2 overrun cleared", 0, 32'(ov_v[0]), 32'd0);

    // 3: glitch then real character
    rxd_v[0] = 1'b0; wait_clks(2 * TDIV); rxd_v[0] = 1'b1;
    wait_clks(2 * 16 * TDIV);
    cmp("t3 glitch count", 0, 32'(cnt_v[0]), 32'd0);
    cmp("t3 glitch flags", 0, 32'({fe_v[0], pe_v[0], ov_v[0]}), 32'd0);
    send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    cmp("t3 rx_out", 0, 32'(out_v[0]), 32'h3C);
    pop(0);

    // 4: even parity on the second instance
    send(1, 8'h07, 1'b0, 1'b1, 1'b0);
    cmp("t4 good count", 1, 32'(cnt_v[1]), 32'd1);
    cmp("t4 good data", 1, 32'(out_v[1]), 32'h07);
    send(1, 8'h07, 1'b1, 1'b1, 1'b0);
    cmp("t4 parity_err", 1, 32'(pe_v[1]), 32'd1);
    cmp("t4 count held", 1, 32'(cnt_v[1]), 32'd1);
    pop(1);
    clear(1);

    // 5: bad stop followed by a long break
    send(0, 8'h81, 1'b0, 1'b0, 1'b0);
    cmp("t5 framing_err", 0, 32'(fe_v[0]), 32'd1);
    wait_clks(20 * 16 * TDIV);
    clear(0);
    wait_clks(20 * 16 * TDIV);
    cmp("t5 single framing", 0, 32'(fe_v[0]), 32'd0);
    cmp("t5 nothing pushed", 0, 32'(cnt_v[0]), 32'd0);
    rxd_v[0] = 1'b1;
    wait_clks(2 * 16 * TDIV);
    send(0, 8'h81, 1'b0, 1'b1, 1'b0);
    cmp("t5 rx_out", 0, 32'(out_v[0]), 32'h81);
    pop(0);

    // 6: full FIFO with a read on the push cycle
    for (int i = 0; i < 4; i++) begin
      fill[i] = 8'($urandom);
      send(0, fill[i], 1'b0, 1'b1, 1'b0);
    end
    nb = 8'($urandom);
    send(0, nb, 1'b0, 1'b1, 1'b1);
    cmp("t6 count", 0, 32'(cnt_v[0]), 32'd4);
    cmp("t6 no overrun", 0, 32'(ov_v[0]), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cmp("t6 order", 0, 32'(out_v[0]), 32'(fill[i]));
      pop(0);
    end
    cmp("t6 last", 0, 32'(out_v[0]), 32'(nb));
    pop(0);

    // 6b: reset in the middle of the data bits
    rxd_v[0] = 1'b0; wait_clks(16 * TDIV);
    rxd_v[0] = 1'b1; wait_clks(16 * TDIV);
    rxd_v[0] = 1'b0; wait_clks(16 * TDIV);
    rst = 1'b1;
    wait_clks(3);
    cmp("t6 reset outputs", 0, 32'({rda_v[0], cnt_v[0], fe_v[0], pe_v[0], ov_v[0]}), 32'd0);
    rxd_v[0] = 1'b1;
    rst = 1'b0;
    wait_clks(2 * 16 * TDIV);
    nb = 8'($urandom);
    send(0, nb, 1'b0, 1'b1, 1'b0);
    cmp("t6 after reset", 0, 32'(out_v[0]), 32'(nb));
    pop(0);

    // Randomized traffic on both instances
    for (int n = 0; n < 24; n++) begin
      int         c;
      logic [7:0] d;
      logic       flip;
      c    = int'($urandom_range(0, 1));
      d    = 8'($urandom);
      flip = (c == 1) && ($urandom_range(0, 3) == 0);
      send(c, d, flip, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) pop(c);
      if ($urandom_range(0, 5) == 0) clear(c);
      wait_clks(int'($urandom_range(0, 40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/spart_rx_fifo.md
Name: spart_rx_fifo

Overview:
Parametrised SPART UART receiver, successor to the single-byte receiver.
- Configurable data width, oversampling ratio and optional parity.
- Received characters go into a FIFO, so the driver can lag several characters without losing data.
- Sticky framing, parity and overrun error flags are visible to the driver.
- Sits between the baud generator (rx_enable tick) and the bus interface/driver.

Parameters:
DATA_BITS, 8, data bits per character, legal 5..8, LSB received first
OVERSAMPLE, 16, rx_enable ticks per bit period, even, legal 4..16
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
FIFO_DEPTH, 4, receive FIFO entries, power of two, legal 2..16

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_enable  in  1  one-clk pulse at OVERSAMPLE x baud rate
rxd  in  1  serial input, asynchronous, idles high
read  in  1  pop FIFO head; one pulse per character
err_clr  in  1  clears all sticky error flags
rda  out  1  FIFO not empty
rx_out  out  DATA_BITS  FIFO head data, valid while rda=1
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO
framing_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: a parity mismatch occurred
overrun  out  1  sticky: a good character arrived while the FIFO was full

Behaviour:
Reset:
- All outputs 0; FIFO empty; pointers 0; FSM in IDLE.
- Synchronizer flops reset to 1.
- Reset mid-frame abandons the frame; no partial push.

Synchronizer:
- rxd passes through 2 flops clocked every clk, independent of rx_enable.
- The FSM uses only the synced value, and samples it only on cycles with rx_enable=1.

FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A tick counter (0..OVERSAMPLE-1) and a bit index run within the states.
- IDLE: on a tick with synced rxd=0, go to START and set counter=1.
- START: at counter=OVERSAMPLE/2 (mid-bit), sample. If 1, false start: return to IDLE. If 0, go to DATA with counter reset.
- DATA: sample every OVERSAMPLE ticks (mid-bit). Shift the sample in at the MSB, shifting right. After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample once. Mismatch is recorded for the stop-bit decision. Even parity means data XOR parity = 0; odd parity means it equals 1.
- STOP: sample once.
  - Sample 1 and no parity mismatch: push the character and go to IDLE.
  - Sample 1 and parity mismatch: set parity_err, discard the character, go to IDLE.
  - Sample 0: set framing_err, discard the character, go to BREAK. A parity mismatch in the same frame also sets parity_err.
- BREAK: wait for a tick with synced rxd=1, then go to IDLE. A held-low line produces exactly one framing error.

FIFO:
- First-word-fall-through: rx_out = mem[rd_ptr] combinationally; rda = (count != 0).
- Push happens on the clk edge of the stop-sample tick. rda and fifo_count update on the next cycle, so latency is 1 clk from the stop-sample tick.
- read with rda=1 pops at the clk edge. read with rda=0 is ignored, with no underflow.
- Push while full with no pop in the same cycle: the character is discarded, overrun is set, and FIFO contents are unchanged.
- Push and pop in the same cycle, including when full: both happen, count is unchanged, and no overrun.
- Pointers wrap modulo FIFO_DEPTH.
- Memory contents are not reset. rx_out is undefined while rda=0, but the bench checks it only when rda=1.

Error flags:
- err_clr clears all error flags on the next edge.
- If a set event and err_clr occur in the same cycle, set wins.
- Error flags never block reception.

Test Plan:
1. Defaults; send 0xA5 (8N1, bit period 16 ticks) -> one stop-sample tick later rda=1, rx_out=0xA5, fifo_count=1; read -> rda=0, count=0.
2. Send 0x11,0x22,0x33,0x44,0x55 with no read (FIFO_DEPTH=4) -> count=4, overrun=1. Reads return 0x11,0x22,0x33,0x44 in order, then rda=0. err_clr -> overrun=0.
3. 2-tick low glitch on rxd in IDLE -> false start, FIFO empty, no flags. Then send 0x3C -> received correctly.
4. PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 1 -> count=1. Send 0x07 with parity bit 0 -> parity_err=1 and count stays 1.
5. Stop bit forced 0 for 0x81, line then held low for 40 bit periods -> exactly one framing_err and nothing pushed. Line released high, then send 0x81 -> received correctly.
6. FIFO full with a character arriving and read asserted on the same clk as the push -> no overrun, count stays 4, order preserved. Reset asserted mid-DATA -> all outputs 0; the next frame is received correctly.
